// File: rtl/jtframe_lfbuf_ctrl_pkg.sv
// Shared types for the line frame buffer external-memory sequencer.
// State encoding and the decoded per-state strobes.
package jtframe_lfbuf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_RD   = 3'd1,
    ST_WR_REQ  = 3'd2,
    ST_WR_CLR  = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WR   = 3'd5
  } state_t;

  typedef struct packed {
    logic fb_clr;
    logic scr_we;
    logic ext_wr;
    logic ext_rd;
  } strobe_t;

endpackage

// File: rtl/jtframe_lfbuf_ctrl.sv
// Per-hblank sequencer: dumps the collected object line to external memory
// (clearing each word), then fetches the next display line from the other frame.
module jtframe_lfbuf_ctrl
  import jtframe_lfbuf_ctrl_pkg::*;
#(
  parameter int            VW   = 8,
  parameter int            HW   = 9,
  parameter logic [HW-1:0] HMAX = 9'd319
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lhbl,
  input  logic              lvbl,
  input  logic [VW-1:0]     vrender,
  input  logic              frame,
  input  logic [VW-1:0]     ln_v,
  input  logic [15:0]       fb_din,
  output logic [HW-1:0]     fb_addr,
  output logic              fb_clr,
  output logic              fb_done,
  output logic              line,
  output logic [HW-1:0]     rd_addr,
  output logic [15:0]       fb_dout,
  output logic              scr_we,
  output logic [HW+VW:0]    ext_addr,
  output logic [15:0]       ext_din,
  output logic              ext_wr,
  output logic              ext_rd,
  input  logic [15:0]       ext_dout,
  input  logic              ext_ack,
  output logic              lost
);

  state_t        state, state_nxt;
  strobe_t       stb;
  logic          lhbl_l;
  logic          hbl_fall;
  logic          last_wr;
  logic          last_rd;
  logic [VW-1:0] v_next;

  assign hbl_fall = lhbl_l & ~lhbl;
  assign last_wr  = fb_addr == HMAX;
  assign last_rd  = rd_addr == HMAX;
  // The fetched line is the one after the current render row, wrapping at VW bits
  assign v_next   = vrender + VW'(1);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hbl_fall) state_nxt = ST_WR_RD;
      ST_WR_RD:  state_nxt = ST_WR_REQ;
      ST_WR_REQ: if (ext_ack) state_nxt = ST_WR_CLR;
      ST_WR_CLR: begin
        if (!last_wr)  state_nxt = ST_WR_RD;
        else if (lvbl) state_nxt = ST_RD_REQ;
        else           state_nxt = ST_IDLE;
      end
      ST_RD_REQ: if (ext_ack) state_nxt = ST_RD_WR;
      ST_RD_WR:  state_nxt = last_rd ? ST_IDLE : ST_RD_REQ;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request and strobe lines decode straight from state, so a reset drops
  // them on the very next cycle without waiting for an acknowledge.
  always_comb begin
    stb = '0;
    case (state)
      ST_WR_REQ: stb.ext_wr = 1'b1;
      ST_WR_CLR: stb.fb_clr = 1'b1;
      ST_RD_REQ: stb.ext_rd = 1'b1;
      ST_RD_WR:  stb.scr_we = 1'b1;
      default:   stb = '0;
    endcase
  end

  assign fb_clr = stb.fb_clr;
  assign scr_we = stb.scr_we;
  assign ext_wr = stb.ext_wr;
  assign ext_rd = stb.ext_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      lhbl_l   <= 1'b0;
      line     <= 1'b0;
      fb_addr  <= '0;
      rd_addr  <= '0;
      fb_dout  <= '0;
      ext_addr <= '0;
      ext_din  <= '0;
      fb_done  <= 1'b0;
      lost     <= 1'b0;
    end else begin
      lhbl_l  <= lhbl;
      fb_done <= state == ST_WR_CLR && last_wr;
      lost    <= hbl_fall && state != ST_IDLE;
      case (state)
        ST_IDLE: begin
          if (hbl_fall) begin
            line    <= ~line;
            fb_addr <= '0;
          end
        end
        ST_WR_RD: begin
          ext_din  <= fb_din;
          ext_addr <= {frame, ln_v, fb_addr};
        end
        ST_WR_CLR: begin
          if (!last_wr) begin
            fb_addr <= fb_addr + HW'(1);
          end else if (lvbl) begin
            rd_addr  <= '0;
            ext_addr <= {~frame, v_next, {HW{1'b0}}};
          end
        end
        ST_RD_REQ: begin
          if (ext_ack) fb_dout <= ext_dout;
        end
        ST_RD_WR: begin
          if (!last_rd) begin
            rd_addr  <= rd_addr + HW'(1);
            ext_addr <= {~frame, v_next, rd_addr + HW'(1)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_lfbuf_ctrl.sv
// Scoreboard bench for jtframe_lfbuf_ctrl with a 4-word line (HMAX=3):
// stimulus queues expected transfers, a negedge monitor pops and compares.
module tb_jtframe_lfbuf_ctrl;

  localparam int            VW   = 8;
  localparam int            HW   = 9;
  localparam int            AW   = HW + VW + 1;
  localparam logic [HW-1:0] HMAX = 9'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lhbl = 1'b1;
  logic          lvbl = 1'b0;
  logic          frame = 1'b0;
  logic [VW-1:0] vrender = '0;
  logic [VW-1:0] ln_v = '0;
  logic [15:0]   fb_din, fb_dout, ext_din, ext_dout;
  logic [HW-1:0] fb_addr, rd_addr;
  logic [AW-1:0] ext_addr;
  logic          fb_clr, fb_done, line, scr_we, ext_wr, ext_rd, lost;
  logic          ext_ack = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t             wr_q[$];
  logic [AW-1:0]   rd_q[$];
  logic [HW+15:0]  scr_q[$];
  logic [HW-1:0]   clr_q[$];

  int   n_pass = 0, n_checks = 0;
  int   done_seen = 0, lost_seen = 0, exp_done = 0, exp_lost = 0;
  int   ack_delay = 0, ack_cnt = 0, exp_gap = 3;
  logic stray_ack_en = 1'b0;
  logic ld_en = 1'b0;
  logic exp_line = 1'b0;
  logic [15:0] pat [4];
  logic [15:0] mem [4];

  jtframe_lfbuf_ctrl #(.VW(VW), .HW(HW), .HMAX(HMAX)) dut (
    .clk(clk), .rst(rst), .lhbl(lhbl), .lvbl(lvbl), .vrender(vrender),
    .frame(frame), .ln_v(ln_v), .fb_din(fb_din), .fb_addr(fb_addr),
    .fb_clr(fb_clr), .fb_done(fb_done), .line(line), .rd_addr(rd_addr),
    .fb_dout(fb_dout), .scr_we(scr_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_wr(ext_wr), .ext_rd(ext_rd), .ext_dout(ext_dout), .ext_ack(ext_ack),
    .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // External memory content: a fixed function of the word address
  function automatic logic [15:0] rd_fn(input logic [AW-1:0] a);
    return a[15:0] ^ {a[17], a[16], 14'h1A5A};
  endfunction

  // Line-input BRAM model: data for the held address, cleared by fb_clr
  assign fb_din   = (fb_addr < 9'd4) ? mem[fb_addr[1:0]] : 16'hDEAD;
  assign ext_dout = ext_rd ? rd_fn(ext_addr) : 16'h0000;

  always @(posedge clk) begin
    if (fb_clr && fb_addr < 9'd4) mem[fb_addr[1:0]] <= 16'h0000;
    else if (ld_en) for (int i = 0; i < 4; i++) mem[i] <= pat[i];
  end

  // Memory responder: acknowledges after ack_delay cycles of a pending request
  always @(posedge clk) begin
    #2;
    if (rst) begin
      ext_ack = 1'b0;
      ack_cnt = 0;
    end else if (ext_wr || ext_rd) begin
      if (ack_cnt == ack_delay) begin
        ext_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        ext_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      ext_ack = stray_ack_en;
      ack_cnt = 0;
    end
  end

  // Monitor
  int            cyc = 0, last_clr_cyc = 0;
  logic          prev_wr = 1'b0, prev_rd = 1'b0, prev_clr_last = 1'b0;
  logic [AW-1:0] held_a = '0;
  logic [15:0]   held_d = '0;
  wr_t           mon_w;
  logic [AW-1:0] mon_a;
  logic [HW+15:0] mon_s;
  logic [HW-1:0] mon_c;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (ext_wr || ext_rd) check("wr_rd_excl", ext_wr & ext_rd, 0);
      if (ext_wr && prev_wr) begin
        check("wr_hold_addr", ext_addr, held_a);
        check("wr_hold_data", ext_din, held_d);
      end
      if (ext_rd && prev_rd) check("rd_hold_addr", ext_addr, held_a);
      if (ext_wr && ext_ack) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", ext_addr, mon_w.addr);
          check("wr_data", ext_din, mon_w.data);
        end
      end
      if (ext_rd && ext_ack) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_a = rd_q.pop_front();
          check("rd_addr", ext_addr, mon_a);
        end
      end
      if (scr_we) begin
        if (scr_q.size() == 0) check("scr_unexpected", 1, 0);
        else begin
          mon_s = scr_q.pop_front();
          check("scr_word", {rd_addr, fb_dout}, mon_s);
        end
      end
      if (fb_clr) begin
        if (clr_q.size() == 0) check("clr_unexpected", 1, 0);
        else begin
          mon_c = clr_q.pop_front();
          check("clr_addr", fb_addr, mon_c);
        end
        if (fb_addr != 0) check("clr_gap", cyc - last_clr_cyc, exp_gap);
        last_clr_cyc = cyc;
      end
      if (fb_done || prev_clr_last) check("done_timing", fb_done, prev_clr_last);
      if (fb_done) done_seen++;
      if (lost) lost_seen++;
    end
    prev_wr       = ext_wr;
    prev_rd       = ext_rd;
    held_a        = ext_addr;
    held_d        = ext_din;
    prev_clr_last = fb_clr && fb_addr == HMAX;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, b, c, d);
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
    tick();
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic expect_line(input logic f, input logic [7:0] lv, vr, input logic rd);
    wr_t           e;
    logic [AW-1:0] a;
    for (int h = 0; h < 4; h++) begin
      e.addr = {f, lv, 9'(h)};
      e.data = pat[h];
      wr_q.push_back(e);
      clr_q.push_back(9'(h));
      if (rd) begin
        a = {~f, vr + 8'd1, 9'(h)};
        rd_q.push_back(a);
        scr_q.push_back({9'(h), rd_fn(a)});
      end
    end
    exp_done++;
  endtask

  task automatic start_line();
    tick();
    lhbl = 1'b1;
    tick();
    lhbl = 1'b0;
    exp_line = ~exp_line;
    @(negedge clk);
    @(negedge clk);
    check("line_toggle", line, exp_line);
  endtask

  task automatic wait_done();
    bit drained = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_q.size() == 0 && rd_q.size() == 0 && scr_q.size() == 0 && clr_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("drained", drained, 1);
    repeat (4) @(negedge clk);
    check("fb_done_count", done_seen, exp_done);
    check("lost_count", lost_seen, exp_lost);
  endtask

  initial begin
    bit got;
    load(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    @(negedge clk);
    check("reset_outputs", {fb_addr, fb_clr, fb_done, line, rd_addr, fb_dout, scr_we,
                            ext_addr, ext_din, ext_wr, ext_rd, lost}, 0);
    tick();
    rst = 1'b0;

    // Reset in the middle of a long write request
    ack_delay = 50;
    ln_v = 8'd5;
    frame = 1'b1;
    start_line();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_wr) begin
        got = 1'b1;
        break;
      end
    end
    check("wr_req_seen", got, 1);
    repeat (2) @(negedge clk);
    check("wr_req_pending", ext_wr, 1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_midreq", {fb_addr, fb_clr, fb_done, line, rd_addr, fb_dout, scr_we,
                             ext_addr, ext_din, ext_wr, ext_rd, lost}, 0);
    end
    rst = 1'b0;
    exp_line = 1'b0;
    ack_delay = 0;
    repeat (2) tick();

    // Acknowledge with no request pending changes nothing
    stray_ack_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_idle", {ext_wr, ext_rd, fb_clr, scr_we, fb_done}, 0);
    end
    tick();
    stray_ack_en = 1'b0;
    repeat (2) tick();

    // Write-only line, immediate ack
    load(16'h1234, 16'hBEEF, 16'h0F0F, 16'hC001);
    ln_v = 8'd5; frame = 1'b1; lvbl = 1'b0; exp_gap = 3;
    expect_line(1'b1, 8'd5, 8'd0, 1'b0);
    start_line();
    wait_done();
    for (int h = 0; h < 4; h++) check("bram_cleared", mem[h], 0);

    // Write then read back the next row from the other frame
    load(16'hA5A5, 16'h0001, 16'h8000, 16'h7E7E);
    lvbl = 1'b1; vrender = 8'd8;
    expect_line(1'b1, 8'd5, 8'd8, 1'b1);
    start_line();
    wait_done();

    // Render row 0xFF: fetched row wraps to 0
    load(16'h0BAD, 16'hF00D, 16'h1357, 16'h2468);
    frame = 1'b0; ln_v = 8'h2C; vrender = 8'hFF;
    expect_line(1'b0, 8'h2C, 8'hFF, 1'b1);
    start_line();
    wait_done();

    // Ack delayed by 5 cycles: 8 cycles per written word
    ack_delay = 5; exp_gap = 8;
    load(16'h5555, 16'hAAAA, 16'hFFFF, 16'h00FF);
    lvbl = 1'b0; frame = 1'b1; ln_v = 8'hA3;
    expect_line(1'b1, 8'hA3, 8'd0, 1'b0);
    start_line();
    wait_done();

    // Hblank edge while reading: lost pulses, transfer completes
    load(16'h3C3C, 16'hC3C3, 16'h6969, 16'h9696);
    lvbl = 1'b1; frame = 1'b0; ln_v = 8'h11; vrender = 8'h40;
    expect_line(1'b0, 8'h11, 8'h40, 1'b1);
    start_line();
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ext_rd) begin
        got = 1'b1;
        break;
      end
    end
    check("rd_req_seen", got, 1);
    tick();
    lhbl = 1'b1;
    tick();
    lhbl = 1'b0;
    exp_lost++;
    repeat (3) @(negedge clk);
    check("line_no_toggle", line, exp_line);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
